rv_instr_encoder: RTL and testbench

//  Inverse of the RV64IM instruction decoder: turns an op index plus rd/rs1/rs2/imm into a 32-bit instruction word.

---
 rtl/rv_instr_encoder.sv | 229 ++++++++++++++++++++++
 tb/tb_rv_instr_encoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: turns an op index plus rd/rs1/rs2/imm into a 32-bit RV64IM instruction word.
// Ports: clk, rst (async, active-high); request stream in_valid/in_ready carrying in_op, in_rd, in_rs1,
//   in_rs2, in_imm; response stream out_valid/out_ready carrying out_instr, out_err; err_cnt (saturating).
// Latency 1 cycle, 1 word/cycle. LI may expand to LUI+ADDIW; the ADDIW waits in a pending register and
//   blocks new requests until it reaches the output. Output holds stable while out_valid & !out_ready.
// Config macro ENC_M_EXT_EN: when defined ops 49-61 encode as M-extension ops, otherwise they are illegal.
module rv_instr_encoder #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_op,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);
    localparam bit IS_RV32 = (XLEN == 32);

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] F7_ALT       = 7'b0100000;
`ifdef ENC_M_EXT_EN
    localparam logic [6:0] F7_MUL       = 7'b0000001;
`endif
    // On RV32 the second LI word is a plain ADDI (same 32-bit result, ADDIW does not exist).
    localparam logic [6:0] OPC_LI_LO    = IS_RV32 ? OPC_OPIMM : OPC_OPIMM32;

    // funct3 for every op index; ops without a funct3 field return 0.
    function automatic logic [2:0] f3_of(input logic [5:0] op);
        case (op)
            6'd5, 6'd11, 6'd18, 6'd27, 6'd32, 6'd41, 6'd46, 6'd50: f3_of = 3'd1;
            6'd12, 6'd19, 6'd22, 6'd33, 6'd51:                     f3_of = 3'd2;
            6'd13, 6'd20, 6'd23, 6'd34, 6'd52:                     f3_of = 3'd3;
            6'd6, 6'd14, 6'd24, 6'd35, 6'd53, 6'd58:               f3_of = 3'd4;
            6'd7, 6'd15, 6'd28, 6'd29, 6'd36, 6'd37, 6'd42, 6'd43,
            6'd47, 6'd48, 6'd54, 6'd59:                            f3_of = 3'd5;
            6'd8, 6'd16, 6'd25, 6'd38, 6'd55, 6'd60:               f3_of = 3'd6;
            6'd9, 6'd26, 6'd39, 6'd56, 6'd61:                      f3_of = 3'd7;
            default:                                               f3_of = 3'd0;
        endcase
    endfunction

    logic signed [31:0] imm_s;
    logic               fits12, fits_b, fits_j, u_ok, shamt_ok, shw_ok;
    logic [19:0]        li_hi;

    assign imm_s    = $signed(in_imm);
    assign fits12   = (imm_s >= -2048) && (imm_s <= 2047);
    assign fits_b   = !in_imm[0] && (imm_s >= -4096) && (imm_s <= 4094);
    assign fits_j   = !in_imm[0] && (imm_s >= -1048576) && (imm_s <= 1048574);
    assign u_ok     = (in_imm[11:0] == 12'h000);
    assign shamt_ok = (in_imm[31:6] == '0) && (!IS_RV32 || !in_imm[5]);
    assign shw_ok   = (in_imm[31:5] == '0);
    // (imm + 0x800) >> 12 modulo 2^20: rounding carry comes from bit 11 of the low part.
    assign li_hi    = in_imm[31:12] + {19'b0, in_imm[11]};

    logic [2:0]  f3;
    logic [31:0] enc_word, enc_second;
    logic        enc_err, enc_two;

    always_comb begin
        f3         = f3_of(in_op);
        enc_word   = '0;
        enc_second = '0;
        enc_err    = 1'b0;
        enc_two    = 1'b0;
        case (in_op) inside
            6'd0: begin
                enc_word = {in_imm[31:12], in_rd, OPC_LUI};
                enc_err  = !u_ok;
            end
            6'd1: begin
                enc_word = {in_imm[31:12], in_rd, OPC_AUIPC};
                enc_err  = !u_ok;
            end
            6'd2: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
                enc_err  = !fits_j;
            end
            6'd3: begin
                enc_word = {in_imm[11:0], in_rs1, f3, in_rd, OPC_JALR};
                enc_err  = !fits12;
            end
            [6'd4:6'd9]: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], OPC_BRANCH};
                enc_err  = !fits_b;
            end
            [6'd10:6'd16]: begin
                enc_word = {in_imm[11:0], in_rs1, f3, in_rd, OPC_LOAD};
                enc_err  = !fits12 || (IS_RV32 && (in_op == 6'd13 || in_op == 6'd16));
            end
            [6'd17:6'd20]: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], OPC_STORE};
                enc_err  = !fits12 || (IS_RV32 && in_op == 6'd20);
            end
            [6'd21:6'd26]: begin
                enc_word = {in_imm[11:0], in_rs1, f3, in_rd, OPC_OPIMM};
                enc_err  = !fits12;
            end
            [6'd27:6'd29]: begin
                enc_word = {1'b0, in_op == 6'd29, 4'b0, in_imm[5:0], in_rs1, f3, in_rd, OPC_OPIMM};
                enc_err  = !shamt_ok;
            end
            [6'd30:6'd39]: begin
                enc_word = {(in_op == 6'd31 || in_op == 6'd37) ? F7_ALT : 7'b0,
                            in_rs2, in_rs1, f3, in_rd, OPC_OP};
            end
            6'd40: begin
                enc_word = {in_imm[11:0], in_rs1, f3, in_rd, OPC_OPIMM32};
                enc_err  = !fits12 || IS_RV32;
            end
            [6'd41:6'd43]: begin
                enc_word = {1'b0, in_op == 6'd43, 5'b0, in_imm[4:0], in_rs1, f3, in_rd, OPC_OPIMM32};
                enc_err  = !shw_ok || IS_RV32;
            end
            [6'd44:6'd48]: begin
                enc_word = {(in_op == 6'd45 || in_op == 6'd48) ? F7_ALT : 7'b0,
                            in_rs2, in_rs1, f3, in_rd, OPC_OP32};
                enc_err  = IS_RV32;
            end
            [6'd49:6'd56]: begin
`ifdef ENC_M_EXT_EN
                enc_word = {F7_MUL, in_rs2, in_rs1, f3, in_rd, OPC_OP};
`else
                enc_err  = 1'b1;
`endif
            end
            [6'd57:6'd61]: begin
`ifdef ENC_M_EXT_EN
                enc_word = {F7_MUL, in_rs2, in_rs1, f3, in_rd, OPC_OP32};
                enc_err  = IS_RV32;
`else
                enc_err  = 1'b1;
`endif
            end
            6'd62: enc_word = 32'h0010_0073;
            default: begin
                // LI: small values fit one ADDI from x0; otherwise LUI, plus a low-part add if non-zero.
                if (fits12) begin
                    enc_word = {in_imm[11:0], 5'd0, 3'd0, in_rd, OPC_OPIMM};
                end else begin
                    enc_word   = {li_hi, in_rd, OPC_LUI};
                    enc_two    = (in_imm[11:0] != 12'h000);
                    enc_second = {in_imm[11:0], in_rd, 3'd0, in_rd, OPC_LI_LO};
                end
            end
        endcase
        if (enc_err) begin
            enc_word = '0;
            enc_two  = 1'b0;
        end
    end

    logic             out_valid_q, out_valid_d, out_err_q, out_err_d, pend_q, pend_d;
    logic [31:0]      out_instr_q, out_instr_d, pend_instr_q, pend_instr_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             slot_free, accept;

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = !pend_q && slot_free;
    assign accept    = in_valid && in_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_err_d    = out_err_q;
        pend_d       = pend_q;
        pend_instr_d = pend_instr_q;
        err_cnt_d    = err_cnt_q;
        if (pend_q && slot_free) begin
            out_valid_d = 1'b1;
            out_instr_d = pend_instr_q;
            out_err_d   = 1'b0;
            pend_d      = 1'b0;
        end else if (accept) begin
            out_valid_d  = 1'b1;
            out_instr_d  = enc_word;
            out_err_d    = enc_err;
            pend_d       = enc_two;
            pend_instr_d = enc_second;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept && enc_err && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_err_q    <= 1'b0;
            pend_q       <= 1'b0;
            pend_instr_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_err_q    <= out_err_d;
            pend_q       <= pend_d;
            pend_instr_q <= pend_instr_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_rv_instr_encoder.sv
// Bench for rv_instr_encoder: directed vectors, expected words queued at accept and
// popped by a monitor on every output handshake; err_cnt, in_ready and reset checked inline.
module tb_rv_instr_encoder;
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [5:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, out_instr;
    logic [CNT_W-1:0] err_cnt;

    rv_instr_encoder #(.XLEN(64), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [32:0] exp_q[$];
    logic [CNT_W-1:0] exp_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every completed output handshake must match the oldest queued expectation.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h expected none", out_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_instr", out_instr, e[31:0]);
                    chk("out_err", {31'b0, out_err}, {31'b0, e[32]});
                end
            end
        end
    end

    // Issue one request; nexp = number of words expected (0 = do not queue), e = expect illegal.
    task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input int nexp,
                        input logic [31:0] w0, input logic [31:0] w1, input logic e);
        int guard;
        @(negedge clk);
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (nexp > 0) begin
            if (e) exp_q.push_back({1'b1, 32'h0});
            else begin
                exp_q.push_back({1'b0, w0});
                if (nexp == 2) exp_q.push_back({1'b0, w1});
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (e && exp_cnt != CMAX) exp_cnt = exp_cnt + 1'b1;
        @(negedge clk);
        chk("err_cnt", {29'b0, err_cnt}, {29'b0, exp_cnt});
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        exp_cnt = '0;
        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_err_cnt", {29'b0, err_cnt}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // addi x1,x0,5 with one-cycle latency
        send(6'd21, 5'd1, 5'd0, 5'd0, 32'd5, 1, 32'h0050_0093, 32'h0, 1'b0);
        chk("lat_valid", {31'b0, out_valid}, 32'd1);
        chk("lat_instr", out_instr, 32'h0050_0093);

        // li x5,0x12345678 -> LUI then ADDIW, in_ready low between them
        send(6'd63, 5'd5, 5'd0, 5'd0, 32'h1234_5678, 2, 32'h1234_52B7, 32'h6782_829B, 1'b0);
        chk("li_pend_rdy", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        chk("li_second_rdy", {31'b0, in_ready}, 32'd1);

        // li x5,0x1000 -> single LUI
        send(6'd63, 5'd5, 5'd0, 5'd0, 32'h0000_1000, 1, 32'h0000_12B7, 32'h0, 1'b0);
        chk("li_single_rdy", {31'b0, in_ready}, 32'd1);

        // near-2^31 LI: hi wraps to 0x80000
        send(6'd63, 5'd5, 5'd0, 5'd0, 32'h7FFF_F800, 2, 32'h8000_02B7, 32'h8002_829B, 1'b0);
        // li x1,-1 -> addi
        send(6'd63, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1, 32'hFFF0_0093, 32'h0, 1'b0);

        // branches and immediate errors
        send(6'd4,  5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1, 32'hFE20_8EE3, 32'h0, 1'b0);
        send(6'd4,  5'd0, 5'd1, 5'd2, 32'd3,         1, 32'h0, 32'h0, 1'b1);
        send(6'd21, 5'd1, 5'd0, 5'd0, 32'd2048,      1, 32'h0, 32'h0, 1'b1);
        send(6'd9,  5'd0, 5'd1, 5'd2, 32'd4094,      1, 32'h7E20_FFE3, 32'h0, 1'b0);
        send(6'd4,  5'd0, 5'd1, 5'd2, 32'd4096,      1, 32'h0, 32'h0, 1'b1);

        // M extension and ebreak
`ifdef ENC_M_EXT_EN
        send(6'd49, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h0220_81B3, 32'h0, 1'b0);
`else
        send(6'd49, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h0, 32'h0, 1'b1);
`endif
        send(6'd62, 5'd0, 5'd0, 5'd0, 32'd0, 1, 32'h0010_0073, 32'h0, 1'b0);

        // shifts, R-type, loads/stores, jumps, upper immediates
        send(6'd29, 5'd1, 5'd2, 5'd0, 32'd63, 1, 32'h43F1_5093, 32'h0, 1'b0);
        send(6'd27, 5'd1, 5'd2, 5'd0, 32'd64, 1, 32'h0, 32'h0, 1'b1);
        send(6'd43, 5'd1, 5'd2, 5'd0, 32'd31, 1, 32'h41F1_509B, 32'h0, 1'b0);
        send(6'd43, 5'd1, 5'd2, 5'd0, 32'd32, 1, 32'h0, 32'h0, 1'b1);
        send(6'd31, 5'd3, 5'd1, 5'd2, 32'd0,  1, 32'h4020_81B3, 32'h0, 1'b0);
        send(6'd20, 5'd0, 5'd2, 5'd3, 32'd8,  1, 32'h0031_3423, 32'h0, 1'b0);
        send(6'd13, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFF8, 1, 32'hFF81_3083, 32'h0, 1'b0);
        send(6'd2,  5'd1, 5'd0, 5'd0, 32'd2048, 1, 32'h0010_00EF, 32'h0, 1'b0);
        send(6'd2,  5'd1, 5'd0, 5'd0, 32'd5,    1, 32'h0, 32'h0, 1'b1);
        send(6'd2,  5'd1, 5'd0, 5'd0, 32'h0010_0000, 1, 32'h0, 32'h0, 1'b1);
        send(6'd0,  5'd1, 5'd0, 5'd0, 32'h1234_5001, 1, 32'h0, 32'h0, 1'b1);
        send(6'd1,  5'd2, 5'd0, 5'd0, 32'hABCD_E000, 1, 32'hABCD_E117, 32'h0, 1'b0);
        drain();
        chk("err_cnt_sat", {29'b0, err_cnt}, {29'b0, CMAX});

        // stall a long LI, then reset: LUI must hold, ADDIW must never appear
        @(negedge clk);
        out_ready = 1'b0;
        send(6'd63, 5'd5, 5'd0, 5'd0, 32'h1234_5678, 0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_instr", out_instr, 32'h1234_52B7);
            chk("hold_rdy", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("rst2_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst2_err_cnt", {29'b0, err_cnt}, 32'd0);
        chk("rst2_in_ready", {31'b0, in_ready}, 32'd1);
        exp_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_addiw", {31'b0, out_valid}, 32'd0);
        end
        send(6'd21, 5'd1, 5'd0, 5'd0, 32'd5, 1, 32'h0050_0093, 32'h0, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
